i_fetch_ctrl: RTL and testbench
===============================

I_FETCH_CTRL -- requirements
Module: i_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter MEMORIA_TAMANHO, default 256, giving the instruction ROM depth in 32-bit words; the value SHALL be a power of two.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port endereco_mem, output, 32 bits: byte address driven to the instruction memory.
REQ-005 The block SHALL have port instrucao_mem, input, 32 bits: combinational instruction word returned by the memory for endereco_mem.
REQ-006 The block SHALL have port desvio_valido, input, 1 bit: branch/jump redirect request.
REQ-007 The block SHALL have port desvio_endereco, input, 32 bits: redirect target byte address.
REQ-008 The block SHALL have port halt_req, input, 1 bit: stop fetching.
REQ-009 The block SHALL have port instrucao_ready, input, 1 bit: consumer accepts instrucao_out this cycle.
REQ-010 The block SHALL have port instrucao_valid, output, 1 bit: instrucao_out/pc_instrucao hold a valid instruction.
REQ-011 The block SHALL have port instrucao_out, output, 32 bits: fetched instruction word.
REQ-012 The block SHALL have port pc_instrucao, output, 32 bits: byte address of instrucao_out.
REQ-013 The block SHALL have port erro_alinhamento, output, 1 bit: one-cycle pulse, misaligned redirect target.
REQ-014 The block SHALL have port parado, output, 1 bit: high while in state HALT.

Function
REQ-015 The FSM SHALL have states INICIO, BUSCA, ESPERA and HALT; it leaves INICIO for BUSCA unconditionally after one cycle, with no fetch issued in INICIO.
REQ-016 endereco_mem SHALL equal the internal PC register combinationally at all times.
REQ-017 In BUSCA, or in ESPERA with instrucao_ready=1, the block SHALL capture instrucao_mem into instrucao_out, PC into pc_instrucao, set instrucao_valid=1 and advance PC by 4, all in the same edge (1-cycle latency).
REQ-018 While instrucao_valid=1 and instrucao_ready=0 the state SHALL be ESPERA, with instrucao_out, pc_instrucao, instrucao_valid and PC held stable.
REQ-019 PC arithmetic SHALL wrap modulo MEMORIA_TAMANHO*4 (0x3FC+4 -> 0x000 at default), with PC bits above that range always zero.
REQ-020 When desvio_valido=1 in INICIO, BUSCA or ESPERA, the next edge SHALL load PC with desvio_endereco, low 2 bits cleared and masked to range, and SHALL clear instrucao_valid, dropping any pending instruction.
REQ-021 When desvio_endereco[1:0]!=0 with desvio_valido=1, erro_alinhamento SHALL pulse high for exactly the next cycle; the redirect still occurs.
REQ-022 When halt_req=1, the next state SHALL be HALT with instrucao_valid=0; HALT SHALL be left only by reset, and desvio_valido SHALL be ignored in HALT.
REQ-023 Priority on one edge SHALL be reset > halt_req > desvio_valido > hold (ESPERA) > advance.
REQ-024 instrucao_ready SHALL be ignored while instrucao_valid=0.

Reset
REQ-025 reset=1 at an edge SHALL force state INICIO, PC=0, instrucao_valid=0, instrucao_out=0, pc_instrucao=0, erro_alinhamento=0, parado=0 and counters=0, from any state including mid-ESPERA and HALT.

Configuration
REQ-026 When macro FETCH_PERF_CNT_EN is defined, the block SHALL add 32-bit outputs contador_instrucoes (incremented on each handshake with valid=1 and ready=1) and contador_stalls (incremented on each cycle with valid=1 and ready=0), both wrapping at 2^32.
REQ-027 When FETCH_PERF_CNT_EN is undefined, those two ports and their logic SHALL be absent, with function otherwise identical.

Verification
REQ-028 The bench SHALL check: reset, then ready held 1, memory word i=i*3 -> first valid 2 cycles after reset release; then instrucao_out=0,3,6..., pc_instrucao=0x0,0x4,0x8 on consecutive cycles.
REQ-029 The bench SHALL check: ready=0 for 3 cycles at pc_instrucao=0x8 -> outputs stable at 0x8 for 3 cycles, contador_stalls=3 (macro on), then 0xC the cycle after ready returns.
REQ-030 The bench SHALL check: desvio_valido with desvio_endereco=0x40 while in ESPERA -> valid=0 next cycle, then pc_instrucao=0x40.
REQ-031 The bench SHALL check: desvio_endereco=0x3FE -> erro_alinhamento pulses 1 cycle; fetch order 0x3FC, 0x000, 0x004 (wrap).
REQ-032 The bench SHALL check: halt_req and desvio_valido asserted together -> HALT, parado=1, valid=0, PC frozen; reset then gives INICIO and fetch from 0x0.

Source files
------------

// File: rtl/i_fetch_ctrl_if.sv
// Bundle of the memory, redirect, control and consumer signals around the
// instruction fetch controller.
// master: the fetch controller itself; slave: memory + pipeline around it.
// Optional performance counters appear only when FETCH_PERF_CNT_EN is defined.
interface i_fetch_ctrl_if;
    logic [31:0] endereco_mem;
    logic [31:0] instrucao_mem;
    logic        desvio_valido;
    logic [31:0] desvio_endereco;
    logic        halt_req;
    logic        instrucao_ready;
    logic        instrucao_valid;
    logic [31:0] instrucao_out;
    logic [31:0] pc_instrucao;
    logic        erro_alinhamento;
    logic        parado;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] contador_instrucoes;
    logic [31:0] contador_stalls;
`endif

    modport master (
        output endereco_mem,
        input  instrucao_mem,
        input  desvio_valido,
        input  desvio_endereco,
        input  halt_req,
        input  instrucao_ready,
        output instrucao_valid,
        output instrucao_out,
        output pc_instrucao,
        output erro_alinhamento,
`ifdef FETCH_PERF_CNT_EN
        output contador_instrucoes,
        output contador_stalls,
`endif
        output parado
    );

    modport slave (
        input  endereco_mem,
        output instrucao_mem,
        output desvio_valido,
        output desvio_endereco,
        output halt_req,
        output instrucao_ready,
        input  instrucao_valid,
        input  instrucao_out,
        input  pc_instrucao,
        input  erro_alinhamento,
`ifdef FETCH_PERF_CNT_EN
        input  contador_instrucoes,
        input  contador_stalls,
`endif
        input  parado
    );
endinterface

// File: rtl/i_fetch_ctrl.sv
// Instruction fetch controller: walks a PC through a MEMORIA_TAMANHO-word ROM,
// presents one instruction at a time with a valid/ready handshake, and accepts
// redirects and a sticky halt. Optional macro: FETCH_PERF_CNT_EN adds
// handshake and stall counters.
// MEMORIA_TAMANHO must be a power of two so that the PC wrap is a plain mask.
module i_fetch_ctrl #(
    parameter int MEMORIA_TAMANHO = 256
) (
    input  logic           clock,
    input  logic           reset,
    i_fetch_ctrl_if.master bus
);

    // Byte-address range of the ROM with the word-offset bits cleared.
    localparam logic [31:0] PC_MASK = (32'(MEMORIA_TAMANHO) * 32'd4 - 32'd1) & ~32'd3;

    // ESPERA means "an instruction is being presented"; BUSCA fetches into an
    // empty output register.
    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        ESPERA = 2'd2,
        HALT   = 2'd3
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_instr_q, pc_instr_d;
    logic        valid_q, valid_d;
    logic        erro_q, erro_d;

    logic [31:0] pc_inc;
    logic [31:0] desvio_alvo;

    assign pc_inc      = (pc_q + 32'd4) & PC_MASK;
    assign desvio_alvo = bus.desvio_endereco & PC_MASK;

    // State and datapath registers, cleared by the synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIO;
            pc_q       <= 32'd0;
            instr_q    <= 32'd0;
            pc_instr_q <= 32'd0;
            valid_q    <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_instr_q <= pc_instr_d;
            valid_q    <= valid_d;
            erro_q     <= erro_d;
        end
    end

    // Next state: halt beats redirect, redirect beats hold, hold beats advance.
    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_instr_d = pc_instr_q;
        valid_d    = valid_q;
        erro_d     = 1'b0;

        if (estado_q == HALT) begin
            // Sticky until reset; redirects are ignored here.
            estado_d = HALT;
            valid_d  = 1'b0;
        end else if (bus.halt_req) begin
            estado_d = HALT;
            valid_d  = 1'b0;
        end else if (bus.desvio_valido) begin
            // Pending instruction is dropped; misaligned target is truncated
            // to the word boundary and flagged for one cycle.
            estado_d = BUSCA;
            pc_d     = desvio_alvo;
            valid_d  = 1'b0;
            erro_d   = |bus.desvio_endereco[1:0];
        end else begin
            case (estado_q)
                INICIO: begin
                    estado_d = BUSCA;
                end
                BUSCA: begin
                    estado_d   = ESPERA;
                    instr_d    = bus.instrucao_mem;
                    pc_instr_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_inc;
                end
                ESPERA: begin
                    // Replace the presented word only once it is taken.
                    if (bus.instrucao_ready) begin
                        instr_d    = bus.instrucao_mem;
                        pc_instr_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                    end
                end
                default: begin
                    estado_d = INICIO;
                end
            endcase
        end
    end

    assign bus.endereco_mem     = pc_q;
    assign bus.instrucao_valid  = valid_q;
    assign bus.instrucao_out    = instr_q;
    assign bus.pc_instrucao     = pc_instr_q;
    assign bus.erro_alinhamento = erro_q;
    assign bus.parado           = (estado_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_instr_q;
    logic [31:0] cnt_stall_q;

    // Handshake and stall counters; both wrap naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_instr_q <= 32'd0;
            cnt_stall_q <= 32'd0;
        end else if (valid_q) begin
            if (bus.instrucao_ready) begin
                cnt_instr_q <= cnt_instr_q + 32'd1;
            end else begin
                cnt_stall_q <= cnt_stall_q + 32'd1;
            end
        end
    end

    assign bus.contador_instrucoes = cnt_instr_q;
    assign bus.contador_stalls     = cnt_stall_q;
`endif

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// Testbench for i_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_i_fetch_ctrl;

    localparam int DEPTH = 256;
    localparam logic [31:0] RANGE_MASK = 32'(DEPTH * 4 - 1);

    logic clk;
    logic rst;
    i_fetch_ctrl_if bus ();

    i_fetch_ctrl #(.MEMORIA_TAMANHO(DEPTH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction ROM.
    logic [31:0] rom [0:DEPTH-1];
    assign bus.instrucao_mem = rom[bus.endereco_mem[9:2]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Rules: after reset one idle cycle, then an instruction is taken from the
    // ROM whenever the output slot is empty or being consumed; a redirect
    // empties the slot and moves the PC; halt freezes everything until reset.
    logic        m_known = 1'b0;
    logic        m_warm, m_halted, m_valid, m_err;
    logic [31:0] m_pc, m_out, m_pcout, m_ci, m_cs;

    always @(posedge clk) begin
        if (rst) begin
            m_known  = 1'b1;
            m_warm   = 1'b0;
            m_halted = 1'b0;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            m_pc     = 32'd0;
            m_out    = 32'd0;
            m_pcout  = 32'd0;
            m_ci     = 32'd0;
            m_cs     = 32'd0;
        end else if (m_known) begin
            if (m_valid && bus.instrucao_ready)  m_ci = m_ci + 1;
            if (m_valid && !bus.instrucao_ready) m_cs = m_cs + 1;
            m_err = 1'b0;
            if (m_halted) begin
                m_valid = 1'b0;
            end else if (bus.halt_req) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
            end else if (bus.desvio_valido) begin
                m_pc    = (bus.desvio_endereco / 4 * 4) % (DEPTH * 4);
                m_valid = 1'b0;
                m_err   = (bus.desvio_endereco % 4) != 0;
                m_warm  = 1'b1;
            end else if (!m_warm) begin
                m_warm = 1'b1;
            end else if (!m_valid || bus.instrucao_ready) begin
                m_out   = rom[m_pc / 4];
                m_pcout = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 4) % (DEPTH * 4);
            end
        end
    end

    // Per-cycle comparison against the model, half a period after the edge.
    always @(negedge clk) begin
        if (m_known) begin
            chk("endereco_mem", bus.endereco_mem, m_pc);
            chk("instrucao_valid", 32'(bus.instrucao_valid), 32'(m_valid));
            chk("erro_alinhamento", 32'(bus.erro_alinhamento), 32'(m_err));
            chk("parado", 32'(bus.parado), 32'(m_halted));
            if (m_valid) begin
                chk("instrucao_out", bus.instrucao_out, m_out);
                chk("pc_instrucao", bus.pc_instrucao, m_pcout);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("contador_instrucoes", bus.contador_instrucoes, m_ci);
            chk("contador_stalls", bus.contador_stalls, m_cs);
`endif
            if (bus.instrucao_valid && bus.instrucao_ready)
                $display("xfer pc=0x%08h instr=0x%08h", bus.pc_instrucao, bus.instrucao_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pin_out(input string tag, input logic [31:0] pc, input logic [31:0] w);
        chk({tag, " valid"}, 32'(bus.instrucao_valid), 32'd1);
        chk({tag, " pc"}, bus.pc_instrucao, pc);
        chk({tag, " instr"}, bus.instrucao_out, w);
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'(i * 3);
        rst                 = 1'b1;
        bus.desvio_valido   = 1'b0;
        bus.desvio_endereco = 32'd0;
        bus.halt_req        = 1'b0;
        bus.instrucao_ready = 1'b1;
        repeat (3) cyc();

        // Reset state.
        chk("rst valid", 32'(bus.instrucao_valid), 32'd0);
        chk("rst out", bus.instrucao_out, 32'd0);
        chk("rst pcout", bus.pc_instrucao, 32'd0);
        chk("rst addr", bus.endereco_mem, 32'd0);
        chk("rst parado", 32'(bus.parado), 32'd0);
        rst = 1'b0;

        // Sequential fetch with ready held high: first valid after 2 edges.
        cyc();
        chk("latency1 valid", 32'(bus.instrucao_valid), 32'd0);
        cyc(); pin_out("seq0", 32'h0, 32'd0);
        cyc(); pin_out("seq1", 32'h4, 32'd3);
        cyc(); pin_out("seq2", 32'h8, 32'd6);

        // Stall three cycles at 0x8.
        bus.instrucao_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(); pin_out("stall", 32'h8, 32'd6);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stalls3", bus.contador_stalls, 32'd3);
`endif
        bus.instrucao_ready = 1'b1;
        cyc(); pin_out("after stall", 32'hC, 32'd9);

        // Redirect to 0x40 while held.
        bus.instrucao_ready = 1'b0;
        cyc(); pin_out("hold C", 32'hC, 32'd9);
        bus.desvio_valido   = 1'b1;
        bus.desvio_endereco = 32'h40;
        cyc();
        chk("desvio valid", 32'(bus.instrucao_valid), 32'd0);
        chk("desvio addr", bus.endereco_mem, 32'h40);
        bus.desvio_valido   = 1'b0;
        bus.instrucao_ready = 1'b1;
        cyc(); pin_out("desvio 40", 32'h40, 32'd48);

        // Misaligned redirect and wrap.
        bus.desvio_valido   = 1'b1;
        bus.desvio_endereco = 32'h3FE;
        cyc();
        chk("align err", 32'(bus.erro_alinhamento), 32'd1);
        chk("align addr", bus.endereco_mem, 32'h3FC);
        bus.desvio_valido = 1'b0;
        cyc(); pin_out("wrap 3FC", 32'h3FC, 32'd765);
        chk("align pulse end", 32'(bus.erro_alinhamento), 32'd0);
        cyc(); pin_out("wrap 000", 32'h0, 32'd0);
        cyc(); pin_out("wrap 004", 32'h4, 32'd3);

        // Halt wins over a simultaneous redirect.
        bus.halt_req        = 1'b1;
        bus.desvio_valido   = 1'b1;
        bus.desvio_endereco = 32'h80;
        cyc();
        chk("halt parado", 32'(bus.parado), 32'd1);
        chk("halt valid", 32'(bus.instrucao_valid), 32'd0);
        chk("halt addr", bus.endereco_mem, 32'h8);
        chk("halt no err", 32'(bus.erro_alinhamento), 32'd0);
        bus.halt_req = 1'b0;
        repeat (2) cyc();
        chk("halt sticky", 32'(bus.parado), 32'd1);
        chk("halt frozen", bus.endereco_mem, 32'h8);
        bus.desvio_valido = 1'b0;
        rst = 1'b1;
        cyc();
        chk("unhalt parado", 32'(bus.parado), 32'd0);
        chk("unhalt addr", bus.endereco_mem, 32'h0);
        rst = 1'b0;
        cyc();
        cyc(); pin_out("restart", 32'h0, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rst                 = (bus.parado ? ($urandom_range(9) == 0) : ($urandom_range(299) == 0));
            bus.halt_req        = ($urandom_range(149) == 0);
            bus.desvio_valido   = ($urandom_range(11) == 0);
            r                   = $urandom;
            bus.desvio_endereco = r[0] ? $urandom : ($urandom & 32'h0000_0FFF);
            bus.instrucao_ready = ($urandom_range(9) < 7);
        end
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
